sample_bram: RTL and testbench



---
 rtl/sample_bram.sv | 47 ++++
 tb/tb_sample_bram.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sample_bram.sv
// sample_bram: single-port read-first block RAM holding the audio history
// for the echo/delay path. Registered read data with one cycle of latency.
// Reset clears only the output register; stored samples survive it.
module sample_bram #(
   parameter int LOGSIZE = 13,
   parameter int WIDTH   = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [LOGSIZE-1:0] addr,
   input  logic               we,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout
);

   localparam int DEPTH = 2 ** LOGSIZE;

   // Power-up contents are zero. The declaration initializer maps onto the
   // RAM init image, so no reset path into the array is needed.
   logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
   logic [WIDTH-1:0] dout_q;
   logic [WIDTH-1:0] dout_d;

   // The read port sees the array as it stood before this edge's write (read-first).
   always_comb begin
      dout_d = mem_q[addr];
   end

   // Write port: writes are suppressed while reset is held low.
   always_ff @(posedge clk) begin
      if (reset_n && we) begin
         mem_q[addr] <= din;
      end
   end

   // Output register: cleared at once by reset, reloaded on every edge otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_sample_bram.sv
// Directed bench for sample_bram. A reference array tracks the memory; each
// access pushes its expected read data onto a scoreboard queue when it is
// driven, and the entry is popped and checked after the clock edge.
module tb_sample_bram;

   localparam int LOGSIZE = 13;
   localparam int WIDTH   = 12;
   localparam int DEPTH   = 2 ** LOGSIZE;

   logic               clk;
   logic               reset_n;
   logic [LOGSIZE-1:0] addr;
   logic               we;
   logic [WIDTH-1:0]   din;
   logic [WIDTH-1:0]   dout;

   logic [WIDTH-1:0]   model [DEPTH];
   logic [WIDTH-1:0]   sb [$];
   int                 total;
   int                 bad;

   sample_bram #(.LOGSIZE(LOGSIZE), .WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .addr   (addr),
      .we     (we),
      .din    (din),
      .dout   (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare dout against a directly supplied expected value.
   task automatic check_val(input string tag, input logic [WIDTH-1:0] exp);
      total++;
      assert (dout === exp) else begin
         bad++;
         $error("FAIL %s: dout=%h expected=%h", tag, dout, exp);
      end
   endtask

   // Pop the oldest scoreboard entry and compare it with dout.
   task automatic check_sb(input string tag);
      logic [WIDTH-1:0] exp;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s: scoreboard empty, dout=%h expected=entry", tag, dout);
      end else begin
         exp = sb.pop_front();
         check_val(tag, exp);
      end
   endtask

   // One access, driven on the falling edge and checked just after the next rising edge.
   task automatic step(input string tag, input logic [LOGSIZE-1:0] a,
                       input logic w, input logic [WIDTH-1:0] d);
      addr = a;
      we   = w;
      din  = d;
      if (reset_n) begin
         sb.push_back(model[a]);
         if (w) model[a] = d;
      end else begin
         sb.push_back('0);
      end
      @(posedge clk);
      #1;
      check_sb(tag);
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      reset_n = 1'b0;
      addr    = '0;
      we      = 1'b0;
      din     = '0;

      // reset state
      #1;
      check_val("reset_dout", '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // power-up contents are zero
      step("pwrup_a0",    13'd0,    1'b0, 12'h000);
      step("pwrup_a5",    13'd5,    1'b0, 12'h000);
      step("pwrup_a8191", 13'd8191, 1'b0, 12'h000);

      // write then read back
      step("wr100",   13'd100, 1'b1, 12'h7FF);
      step("rd100",   13'd100, 1'b0, 12'h000);
      check_val("rd100_const", 12'h7FF);

      // read-first on a simultaneous read/write
      step("wr7_old", 13'd7, 1'b1, 12'h123);
      step("wr7_new", 13'd7, 1'b1, 12'hABC);
      check_val("rdw_old_const", 12'h123);
      step("rd7",     13'd7, 1'b0, 12'h000);
      check_val("rd7_const", 12'hABC);

      // writes ignored while reset is held
      reset_n = 1'b0;
      #1;
      check_val("rst_hold_dout", '0);
      step("rst_wr3", 13'd3, 1'b1, 12'hFFF);
      reset_n = 1'b1;
      step("rd3", 13'd3, 1'b0, 12'h000);
      check_val("rd3_const", 12'h000);

      // async reset pulse between edges keeps memory contents
      step("wr42", 13'd42, 1'b1, 12'h800);
      step("rd42", 13'd42, 1'b0, 12'h000);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("async_rst", '0);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      step("rd42_post", 13'd42, 1'b0, 12'h000);
      check_val("rd42_const", 12'h800);

      // fill the whole array, then read it back including wrap to address 0
      for (int i = 0; i < DEPTH; i++) begin
         logic [LOGSIZE-1:0] a;
         a = LOGSIZE'(i);
         step("fill", a, 1'b1, a[11:0] ^ 12'h5A5);
      end
      for (int i = 0; i <= DEPTH; i++) begin
         logic [LOGSIZE-1:0] a;
         a = LOGSIZE'(i);
         step("readback", a, 1'b0, 12'h000);
      end
      check_val("wrap_a0_const", 12'h5A5);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $error("FAIL sb_drain: left=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: sim time=%0t limit=2000000", $time);
      $fatal(1, "timeout");
   end

endmodule
